// File: rtl/accumulate_pkg.sv
// Shared types and saturating arithmetic for the accumulate datapath.
package accumulate_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam int DEF_W = 16;

  function automatic logic signed [63:0] res_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] res_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  localparam logic signed [63:0] RES_MAX = res_max(DEF_W);
  localparam logic signed [63:0] RES_MIN = res_min(DEF_W);

  // Operands are already inside the w-bit range, so a wide add is exact
  // and equivalent to the (w+1)-bit add before clamping.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] acc,
                                                 input logic signed [63:0] term,
                                                 input int w);
    logic signed [63:0] sum;
    sum = acc + term;
    if (sum > res_max(w))      return res_max(w);
    else if (sum < res_min(w)) return res_min(w);
    else                       return sum;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set req bit at ptr, ptr+1, ... mod N.
module rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 any,
  output logic [$clog2(N)-1:0] idx
);
  localparam int IW = $clog2(N);

  logic [2*N-1:0] rot;
  logic [IW:0]    pos;

  // Rotating the doubled vector puts the search start at bit 0.
  always_comb begin
    rot = {req, req} >> ptr;
    any = 1'b0;
    idx = '0;
    pos = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        any = 1'b1;
        pos = {1'b0, ptr} + (IW+1)'(i);
        if (pos >= (IW+1)'(N)) pos = pos - (IW+1)'(N);
        idx = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/accumulate_arbiter.sv
// Round-robin shares one saturating accumulator across N burst requesters,
// emitting each burst sum tagged with its requester index.
module accumulate_arbiter
  import accumulate_pkg::*;
#(
  parameter int N = 2,
  parameter int W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         arg_stb,
  input  logic [N*W-1:0]       arg_dat,
  input  logic [N-1:0]         arg_lst,
  output logic [N-1:0]         arg_rdy,
  output logic                 res_stb,
  output logic [W-1:0]         res_dat,
  output logic [$clog2(N)-1:0] res_idx,
  input  logic                 res_rdy
);
  localparam int IW = $clog2(N);

  state_t             state_q, state_d;
  logic [IW-1:0]      grant_q, grant_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [W-1:0]       acc_q, acc_d;
  logic               pick_any;
  logic [IW-1:0]      pick_idx;
  logic [W-1:0]       term;
  logic signed [63:0] sum_w;

  rr_pick #(.N(N)) u_pick (
    .req (arg_stb),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign term  = arg_dat[grant_q*W +: W];
  assign sum_w = sat_add(64'($signed(acc_q)), 64'($signed(term)), W);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: if (pick_any) begin
        grant_d = pick_idx;
        acc_d   = '0;
        state_d = ACC;
      end
      // Grant is held until the last beat; other strobes are ignored.
      ACC: if (arg_stb[grant_q]) begin
        acc_d = sum_w[W-1:0];
        if (arg_lst[grant_q]) state_d = OUT;
      end
      OUT: if (res_rdy) begin
        ptr_d   = (grant_q == IW'(N - 1)) ? '0 : grant_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    arg_rdy = '0;
    if (state_q == ACC) arg_rdy[grant_q] = 1'b1;
  end

  assign res_stb = (state_q == OUT);
  assign res_dat = acc_q;
  assign res_idx = grant_q;

endmodule

// File: tb/tb_accumulate_arbiter.sv
// Directed plus randomized bench for accumulate_arbiter against a per-requester burst-sum model.
module tb_accumulate_arbiter;
  localparam int N = 3;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   arg_stb = '0;
  logic [N*W-1:0] arg_dat = '0;
  logic [N-1:0]   arg_lst = '0;
  logic [N-1:0]   arg_rdy;
  logic           res_stb;
  logic [W-1:0]   res_dat;
  logic [1:0]     res_idx;
  logic           res_rdy = 1'b0;

  int checks = 0;
  int failures = 0;

  int tq[N][$];
  bit lq[N][$];
  int expq[N][$];
  int macc[N];
  int got_idx[$];
  int got_dat[$];

  accumulate_arbiter #(.N(N), .W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .arg_stb (arg_stb),
    .arg_dat (arg_dat),
    .arg_lst (arg_lst),
    .arg_rdy (arg_rdy),
    .res_stb (res_stb),
    .res_dat (res_dat),
    .res_idx (res_idx),
    .res_rdy (res_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Model: running clamped sum per requester, one expected result per burst.
  task automatic push_beat(input int n, input int t, input bit l);
    tq[n].push_back(t);
    lq[n].push_back(l);
    macc[n] = macc[n] + t;
    if (macc[n] > 32767) macc[n] = 32767;
    else if (macc[n] < -32768) macc[n] = -32768;
    if (l) begin
      expq[n].push_back(macc[n]);
      macc[n] = 0;
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int n = 0; n < N; n++) s += tq[n].size() + expq[n].size();
    return s;
  endfunction

  // Called at posedge+1; drives queued beats, checks protocol at negedge.
  // rdy_mode: 0 always ready, 1 random ready, 2 hold ready low 5 cycles once.
  task automatic run(input int budget, input int gap_pct, input int rdy_mode);
    int cyc = 0;
    int held = 0;
    bit stb_on[N];
    bit lst_prev = 0;
    bit hold_prev = 0;
    bit owner_v = 0;
    int owner = 0;
    logic [W-1:0] prev_dat = '0;
    logic [1:0]   prev_idx = '0;
    got_idx.delete();
    got_dat.delete();
    for (int n = 0; n < N; n++) stb_on[n] = 0;
    while (pending() != 0 && cyc < budget) begin
      for (int n = 0; n < N; n++) begin
        if (tq[n].size() == 0) stb_on[n] = 0;
        else if (!stb_on[n] && $urandom_range(99) >= gap_pct) stb_on[n] = 1;
        arg_stb[n] = stb_on[n];
        arg_dat[n*W +: W] = stb_on[n] ? 16'(tq[n][0]) : 16'($urandom);
        arg_lst[n] = stb_on[n] ? lq[n][0] : 1'($urandom);
      end
      case (rdy_mode)
        0: res_rdy = 1'b1;
        1: res_rdy = 1'($urandom);
        default: begin
          if (res_stb && held < 5) begin
            res_rdy = 1'b0;
            held++;
          end else res_rdy = 1'b1;
        end
      endcase
      @(negedge clk);
      chk("rdy_onehot0", ($countones(arg_rdy) <= 1), 1);
      if (owner_v) chk("burst_lock", arg_rdy, (1 << owner));
      if (res_stb) chk("rdy_zero_in_out", arg_rdy, 0);
      if (lst_prev) chk("res_after_lst", res_stb, 1);
      if (hold_prev) begin
        chk("hold_stb", res_stb, 1);
        chk("hold_dat", res_dat, prev_dat);
        chk("hold_idx", res_idx, prev_idx);
      end
      lst_prev = 0;
      for (int n = 0; n < N; n++) begin
        if (arg_stb[n] && arg_rdy[n] && tq[n].size() > 0) begin
          if (lq[n][0]) begin
            owner_v  = 0;
            lst_prev = 1;
          end else begin
            owner_v = 1;
            owner   = n;
          end
          void'(tq[n].pop_front());
          void'(lq[n].pop_front());
          stb_on[n] = 0;
        end
      end
      hold_prev = res_stb && !res_rdy;
      prev_dat  = res_dat;
      prev_idx  = res_idx;
      if (res_stb && res_rdy) begin
        if (res_idx < N && expq[res_idx].size() > 0) begin
          chk("res_dat", $signed(res_dat), expq[res_idx][0]);
          void'(expq[res_idx].pop_front());
          got_idx.push_back(int'(res_idx));
          got_dat.push_back(int'($signed(res_dat)));
        end else begin
          chk("res_unexpected_idx", res_idx, -1);
        end
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("run_pending", pending(), 0);
    for (int n = 0; n < N; n++) begin
      tq[n].delete();
      lq[n].delete();
      expq[n].delete();
      macc[n] = 0;
    end
    arg_stb = '0;
    res_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_no_res", res_stb, 0);
      chk("idle_rdy", arg_rdy, 0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    for (int n = 0; n < N; n++) macc[n] = 0;

    // Reset with random inputs
    for (int k = 0; k < 4; k++) begin
      arg_stb = 3'($urandom);
      arg_lst = 3'($urandom);
      arg_dat = {16'($urandom), 16'($urandom), 16'($urandom)};
      res_rdy = 1'($urandom);
      @(negedge clk);
      chk("rst_res_stb", res_stb, 0);
      chk("rst_res_dat", res_dat, 0);
      chk("rst_res_idx", res_idx, 0);
      chk("rst_arg_rdy", arg_rdy, 0);
    end

    // First grant after release: lowest requester at or after 0
    arg_stb = 3'b110;
    arg_lst = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("first_grant", arg_rdy, 3'b010);
    rst = 1'b0;
    #1;
    chk("async_rst_rdy", arg_rdy, 0);
    arg_stb = '0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Basic burst
    push_beat(0, 3, 0);
    push_beat(0, 4, 0);
    push_beat(0, -2, 1);
    run(200, 0, 0);
    chk("basic_count", got_dat.size(), 1);
    if (got_dat.size() == 1) begin
      chk("basic_dat", got_dat[0], 5);
      chk("basic_idx", got_idx[0], 0);
    end

    // Saturation, clamped per beat
    push_beat(1, 30000, 0);
    push_beat(1, 10000, 0);
    push_beat(1, -5, 1);
    push_beat(1, -30000, 0);
    push_beat(1, -10000, 1);
    run(200, 0, 0);
    chk("sat_count", got_dat.size(), 2);
    if (got_dat.size() == 2) begin
      chk("sat_pos", got_dat[0], 32762);
      chk("sat_neg", got_dat[1], -32768);
      chk("sat_idx", got_idx[1], 1);
    end

    // Round-robin with both requesters streaming
    push_beat(0, 1, 0); push_beat(0, 2, 1);
    push_beat(0, 3, 0); push_beat(0, 4, 1);
    push_beat(1, 5, 0); push_beat(1, 6, 1);
    push_beat(1, 7, 0); push_beat(1, 8, 1);
    run(300, 0, 0);
    chk("rr_count", got_idx.size(), 4);
    if (got_idx.size() == 4) begin
      for (int k = 0; k < 4; k++) chk("rr_order", got_idx[k], k % 2);
    end

    // Backpressure
    push_beat(2, 11, 0);
    push_beat(2, 22, 1);
    run(200, 0, 2);
    chk("bp_count", got_dat.size(), 1);
    if (got_dat.size() == 1) begin
      chk("bp_dat", got_dat[0], 33);
      chk("bp_idx", got_idx[0], 2);
    end

    // Mid-burst reset after 2 of 4 beats
    arg_stb = 3'b001;
    arg_lst = '0;
    arg_dat[0 +: W] = 16'd10;
    @(posedge clk); #1;
    @(posedge clk); #1;
    arg_dat[0 +: W] = 16'd20;
    @(posedge clk); #1;
    arg_dat[0 +: W] = 16'd30;
    rst = 1'b0;
    #1;
    chk("midrst_res_stb", res_stb, 0);
    chk("midrst_res_dat", res_dat, 0);
    chk("midrst_res_idx", res_idx, 0);
    chk("midrst_arg_rdy", arg_rdy, 0);
    arg_stb = '0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    push_beat(0, 100, 0);
    push_beat(0, 200, 0);
    push_beat(0, 300, 1);
    run(200, 0, 0);
    chk("midrst_count", got_dat.size(), 1);
    if (got_dat.size() == 1) chk("midrst_fresh_acc", got_dat[0], 600);

    // Randomized bursts, gaps and backpressure
    for (int n = 0; n < N; n++) begin
      for (int b = 0; b < 6; b++) begin
        int len;
        len = $urandom_range(1, 5);
        for (int j = 0; j < len; j++) begin
          int t;
          if ($urandom_range(3) == 0) t = int'($urandom_range(65535)) - 32768;
          else t = int'($urandom_range(200)) - 100;
          push_beat(n, t, j == len - 1);
        end
      end
    end
    run(20000, 30, 1);
    chk("rand_count", got_dat.size(), 18);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/accumulate_arbiter.md
Name: accumulate_arbiter

Overview:
Shares one saturating signed accumulator among N requester streams. Each requester presents a burst of W-bit terms terminated by a last flag. Requesters are granted one whole burst at a time in round-robin order. The block emits the saturated burst sum tagged with the requester index. It sits between the upstream term producers and the downstream result consumer in the accumulate datapath.

Parameters:
N, 2, number of requesters (N >= 2)
W, 16, term and result width, two's complement
IW, $clog2(N), width of the requester index (derived localparam, not overridable)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
arg_stb  input  N  per-requester term valid
arg_dat  input  N*W  per-requester term; requester n occupies bits [n*W +: W]
arg_lst  input  N  per-requester last term of burst; qualified by arg_stb
arg_rdy  output  N  per-requester accept; one-hot or zero
res_stb  output  1  result valid
res_dat  output  W  saturated burst sum
res_idx  output  IW  index of the requester that produced res_dat
res_rdy  input  1  result accept

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, grant=0, ptr=0, acc=0.
  - res_stb=0, res_dat=0, res_idx=0, arg_rdy=0.
  - A burst in progress when reset asserts is abandoned; no partial result is emitted.
- FSM states: IDLE, ACC, OUT.
- IDLE:
  - arg_rdy=0.
  - If any arg_stb is set, select the first set bit searching ptr, ptr+1, ... with wrap at N.
  - Register that index as grant, clear acc to 0, go to ACC.
  - If no arg_stb is set, stay in IDLE.
  - Arbitration costs exactly 1 cycle.
- ACC:
  - arg_rdy[grant]=1 (combinational from state and grant); all other arg_rdy bits are 0.
  - A beat transfers when arg_stb[grant] && arg_rdy[grant].
  - On a transfer: acc <= sat(acc + sext(arg_dat[grant])).
  - If arg_lst[grant] is set on that transfer, go to OUT.
  - If arg_stb[grant] is low, hold; the grant is never revoked mid-burst.
  - Other requesters' strobes are ignored until the burst completes.
- OUT:
  - res_stb=1, res_dat=acc, res_idx=grant; arg_rdy=0.
  - res_dat and res_idx are held stable while res_rdy is low.
  - On res_stb && res_rdy: ptr <= (grant+1) mod N, go to IDLE.
  - Minimum cycle per burst of K beats: 1 (IDLE) + K (ACC) + 1 (OUT).
- Arithmetic:
  - Sum is computed in W+1 bits, then clamped to [-(2^(W-1)), 2^(W-1)-1].
  - Clamping is applied on every beat, not only at burst end. Example: max + (-5) = max - 5.
- Single-beat burst (arg_lst set on the first beat) is legal; result equals that term.
- Empty bursts are not possible.
- arg_dat and arg_lst of a requester must stay stable while its arg_stb is high and it is not accepted. This is an upstream obligation and is not checked.
- A result is never dropped or duplicated.
- Fairness: with all N requesters continuously requesting, grants cycle 0,1,...,N-1,0,...

Decomposition:
- Package accumulate_pkg holds:
  - function sat_add(acc, term, W), giving (W+1)-bit add plus clamp;
  - the RES_MAX and RES_MIN constants;
  - the state enum {IDLE, ACC, OUT}.
- Sub-module rr_pick (N): combinational round-robin first-set search.
  - Inputs: req[N], ptr[IW].
  - Outputs: any, idx[IW].
  - Instantiated once, and reusable by other arbiters in the datapath.
- Remaining FSM, accumulator and output registers stay in accumulate_arbiter.

Test Plan:
- Reset: hold rst low with random inputs -> res_stb=0, res_dat=0, res_idx=0, arg_rdy=0; after release, first grant goes to the lowest requesting index at or after 0.
- Basic burst, W=16: req0 sends 3, 4, -2 (lst on -2) -> one result res_dat=5, res_idx=0; res_stb rises the cycle after the lst beat.
- Positive saturation: req1 sends 30000, 10000, -5 (lst) -> res_dat=32762. Negative saturation: -30000, -10000 (lst) -> res_dat=-32768.
- Round-robin and lock: req0 and req1 both stream 2-beat bursts continuously -> result idx order 0,1,0,1. While req0's burst is open, arg_rdy[1] stays 0 even with arg_stb[1]=1.
- Backpressure: hold res_rdy low 5 cycles in OUT -> res_dat and res_idx stable, arg_rdy=0 throughout; on res_rdy=1, exactly one result is accepted and the FSM returns to IDLE.
- Mid-burst reset: assert rst low after 2 of 4 beats -> outputs reset immediately with no result emitted; a new burst after release starts from acc=0.
